// File: rtl/us_ranger.sv
`default_nettype none
// ============================================================================
//  Module   : us_ranger
//  Purpose  : Ultrasonic ranging front-end for one single-signal ping sensor.
//             Each measurement cycle drives a trigger pulse on the shared
//             sensor line, releases it, times the returning echo pulse and
//             converts the echo width to an 8-bit distance
//             (one unit per CYCLES_PER_UNIT clocks, saturating at 255).
//  Ports    : CLK         - system clock, rising edge
//             RST         - synchronous active-high reset
//             ENABLE      - 1 = run periodic measurements
//             US_SIG      - bidirectional sensor line (driven or Z)
//             DISTANCE    - last measured distance, held between updates
//             VALID       - one-cycle strobe when DISTANCE/TIMEOUT_ERR update
//             TIMEOUT_ERR - 1 = last measurement timed out
//             BUSY        - 1 = FSM is not idle
//  Revision : 1.0 - initial release
// ============================================================================
module us_ranger #(
    parameter int TRIG_CYCLES     = 250,
    parameter int HOLDOFF_CYCLES  = 100,
    parameter int CYCLES_PER_UNIT = 7400,
    parameter int TIMEOUT_CYCLES  = 1000000,
    parameter int PERIOD_CYCLES   = 3000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ENABLE,
    inout  wire        US_SIG,
    output logic [7:0] DISTANCE,
    output logic       VALID,
    output logic       TIMEOUT_ERR,
    output logic       BUSY
);

    localparam int c_CNT_W = 22;
    localparam int c_SUB_W = (CYCLES_PER_UNIT > 1) ? $clog2(CYCLES_PER_UNIT) : 1;

    localparam logic [c_CNT_W-1:0] c_TRIG_LAST    = c_CNT_W'(TRIG_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_HOLDOFF_LAST = c_CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_PERIOD_LAST  = c_CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [c_SUB_W-1:0] c_SUB_LAST     = c_SUB_W'(CYCLES_PER_UNIT - 1);

    localparam logic [2:0] c_S_IDLE        = 3'd0;
    localparam logic [2:0] c_S_TRIG        = 3'd1;
    localparam logic [2:0] c_S_HOLDOFF     = 3'd2;
    localparam logic [2:0] c_S_WAIT_RISE   = 3'd3;
    localparam logic [2:0] c_S_MEASURE     = 3'd4;
    localparam logic [2:0] c_S_DONE        = 3'd5;
    localparam logic [2:0] c_S_WAIT_PERIOD = 3'd6;

    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;       // time spent in the current state
    logic [c_CNT_W-1:0] r_period;    // time since the last trigger started
    logic [c_SUB_W-1:0] r_sub;
    logic [7:0]         r_dist;
    logic [7:0]         r_distance;
    logic               r_valid;
    logic               r_terr;
    logic               r_sync1;
    logic               r_sync2;
    logic               r_sync_d;

    logic               w_rise;
    logic               w_fall;
    logic               w_sub_wrap;
    logic [7:0]         w_dist_nxt;
    logic               w_oe;
    logic               w_out;

    // The line is only released while listening for the echo; everywhere
    // else (reset, idle, trigger, inter-measurement gap) it is held driven.
    assign w_oe   = !((r_state == c_S_HOLDOFF) || (r_state == c_S_WAIT_RISE) ||
                      (r_state == c_S_MEASURE) || (r_state == c_S_DONE));
    assign w_out  = (r_state == c_S_TRIG);
    assign US_SIG = w_oe ? w_out : 1'bz;

    // Edges are taken on the synchronized value, so both edges carry the same
    // two-cycle delay and the measured width equals the pin width.
    assign w_rise = r_sync2 & ~r_sync_d;
    assign w_fall = ~r_sync2 & r_sync_d;

    // Distance count including the current MEASURE cycle; used both for the
    // running counter and for the capture on the falling edge.
    assign w_sub_wrap = (r_sub == c_SUB_LAST);
    assign w_dist_nxt = (w_sub_wrap && (r_dist != 8'hFF)) ? r_dist + 8'd1 : r_dist;

    assign DISTANCE    = r_distance;
    assign VALID       = r_valid;
    assign TIMEOUT_ERR = r_terr;
    assign BUSY        = (r_state != c_S_IDLE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_sync_d <= 1'b0;
        end else begin
            r_sync1  <= US_SIG;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= c_S_IDLE;
            r_cnt      <= '0;
            r_period   <= '0;
            r_sub      <= '0;
            r_dist     <= '0;
            r_distance <= '0;
            r_valid    <= 1'b0;
            r_terr     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            // Saturates so an overrun measurement leaves a one-cycle gap.
            if (r_period != c_PERIOD_LAST) begin
                r_period <= r_period + 1'b1;
            end

            case (r_state)
                c_S_IDLE: begin
                    if (ENABLE) begin
                        r_state  <= c_S_TRIG;
                        r_cnt    <= '0;
                        r_period <= '0;
                    end
                end

                c_S_TRIG: begin
                    if (r_cnt == c_TRIG_LAST) begin
                        r_state <= c_S_HOLDOFF;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                c_S_HOLDOFF: begin
                    if (r_cnt == c_HOLDOFF_LAST) begin
                        r_state <= c_S_WAIT_RISE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                c_S_WAIT_RISE: begin
                    if (w_rise) begin
                        r_state <= c_S_MEASURE;
                        r_cnt   <= '0;
                        r_sub   <= '0;
                        r_dist  <= '0;
                    end else if (r_cnt == c_TIMEOUT_LAST) begin
                        r_state    <= c_S_DONE;
                        r_distance <= 8'hFF;
                        r_terr     <= 1'b1;
                        r_valid    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                c_S_MEASURE: begin
                    // The fall-detect cycle is the last of W counted cycles:
                    // the rise-detect cycle itself was spent in WAIT_RISE.
                    r_sub  <= w_sub_wrap ? '0 : r_sub + 1'b1;
                    r_dist <= w_dist_nxt;
                    if (w_fall) begin
                        r_state    <= c_S_DONE;
                        r_distance <= w_dist_nxt;
                        r_terr     <= 1'b0;
                        r_valid    <= 1'b1;
                    end else if (r_cnt == c_TIMEOUT_LAST) begin
                        r_state    <= c_S_DONE;
                        r_distance <= 8'hFF;
                        r_terr     <= 1'b1;
                        r_valid    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                c_S_DONE: begin
                    r_state <= c_S_WAIT_PERIOD;
                end

                c_S_WAIT_PERIOD: begin
                    if (r_period == c_PERIOD_LAST) begin
                        if (ENABLE) begin
                            r_state  <= c_S_TRIG;
                            r_cnt    <= '0;
                            r_period <= '0;
                        end else begin
                            r_state <= c_S_IDLE;
                        end
                    end
                end

                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
